// File: rtl/seq_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_round_ctrl
// Description : Round controller for the memory game. Pulses the sequence
//               register load enable, plays the first N nibbles of the stored
//               64-bit sequence on the LED output, then checks N key presses
//               against them, reporting hit/miss, round, win and lose.
//               Optional feature macro: KEY_TIMEOUT_EN (key wait time limit).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_round_ctrl #(
    parameter int N_NIBBLES      = 16,
    parameter int SHOW_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        R,
    input  logic        start,
    input  logic [63:0] seq_q,
    input  logic        key_valid,
    input  logic [3:0]  key,
    output logic        reg_E,
    output logic [3:0]  led,
    output logic        led_valid,
    output logic [4:0]  round_out,
    output logic        hit,
    output logic        miss,
    output logic        busy,
    output logic        win,
    output logic        lose
);

    // One timer serves the show/gap phases and, when enabled, the key wait
    // limit; it is sized for the longest of the three intervals.
    localparam int MAX_SG   = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int MAX_T    = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
    localparam int TMR_W    = $clog2(MAX_T + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHOW     = 3'd2,
        S_GAP      = 3'd3,
        S_WAIT_KEY = 3'd4,
        S_WIN      = 3'd5,
        S_LOSE     = 3'd6
    } state_t;

    state_t             state;
    logic [3:0]         idx;
    logic [TMR_W-1:0]   timer;

    logic [3:0]         nib [16];
    logic [3:0]         nib_cur;
    logic               idx_last;

    // Nibble i of the sequence, most significant nibble first.
    for (genvar g = 0; g < 16; g++) begin : g_nib
        assign nib[g] = seq_q[63 - 4*g -: 4];
    end

    assign nib_cur  = nib[idx];
    assign idx_last = ({1'b0, idx} == (round_out - 5'd1));

    // Game sequencing; every output is a registered copy of the FSM decision.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state     <= S_IDLE;
            idx       <= 4'd0;
            timer     <= '0;
            reg_E     <= 1'b0;
            led       <= 4'd0;
            led_valid <= 1'b0;
            round_out <= 5'd0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            busy      <= 1'b0;
            win       <= 1'b0;
            lose      <= 1'b0;
        end else begin
            hit   <= 1'b0;
            miss  <= 1'b0;
            reg_E <= 1'b0;
            case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        reg_E     <= 1'b1;
                        round_out <= 5'd1;
                        idx       <= 4'd0;
                        timer     <= '0;
                        win       <= 1'b0;
                        lose      <= 1'b0;
                        busy      <= 1'b1;
                        led_valid <= 1'b0;
                    end
                end
                // The register captures at the end of LOAD, so seq_q is
                // only trusted from the first SHOW cycle onward.
                S_LOAD: begin
                    state <= S_SHOW;
                    timer <= '0;
                end
                S_SHOW: begin
                    led       <= nib_cur;
                    led_valid <= 1'b1;
                    if (timer == TMR_W'(SHOW_CYCLES - 1)) begin
                        timer <= '0;
                        state <= S_GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_GAP: begin
                    led_valid <= 1'b0;
                    if (timer == TMR_W'(GAP_CYCLES - 1)) begin
                        timer <= '0;
                        if (idx_last) begin
                            idx   <= 4'd0;
                            state <= S_WAIT_KEY;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= S_SHOW;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WAIT_KEY: begin
                    led_valid <= 1'b0;
                    if (key_valid) begin
                        timer <= '0;
                        if (key == nib_cur) begin
                            hit <= 1'b1;
                            if (!idx_last) begin
                                idx <= idx + 4'd1;
                            end else if (round_out == 5'(N_NIBBLES)) begin
                                state <= S_WIN;
                                win   <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                round_out <= round_out + 5'd1;
                                idx       <= 4'd0;
                                state     <= S_SHOW;
                            end
                        end else begin
                            miss  <= 1'b1;
                            lose  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_LOSE;
                        end
                    end
`ifdef KEY_TIMEOUT_EN
                    // A key in the limit cycle wins over the timeout above.
                    else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        timer <= '0;
                        miss  <= 1'b1;
                        lose  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_LOSE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`else
                    // Without the limit the player may take forever.
`endif
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/seq_round_ctrl.md
Name: seq_round_ctrl

Overview:
Round controller for the memory-game datapath. It pulses the load enable of the 64-bit sequence register and reads the stored sequence back as 16 nibbles, most significant first. Each round it plays the first N nibbles on the LED output, then checks N player key presses against them. It reports hit/miss per key, the current round, and a final win or lose, and sits between the sequence register, the LED/display driver and the debounced keypad.

Parameters:
N_NIBBLES, 16, number of 4-bit symbols in the 64-bit sequence (max rounds)
SHOW_CYCLES, 4, clock cycles each nibble is held on led with led_valid=1
GAP_CYCLES, 2, blank cycles (led_valid=0) after each shown nibble
TIMEOUT_CYCLES, 32, key wait limit; used only with KEY_TIMEOUT_EN

Ports:
clk  in  1  clock, rising edge
R  in  1  asynchronous active-high reset
start  in  1  level; begins a new game when sampled high in IDLE, WIN or LOSE
seq_q  in  64  sequence register output; nibble i = seq_q[63-4i -: 4]
key_valid  in  1  one-cycle strobe, player pressed a key
key  in  4  key code, valid with key_valid
reg_E  out  1  load enable to sequence register, one-cycle pulse
led  out  4  nibble being shown
led_valid  out  1  led is meaningful
round_out  out  5  current round, 0..16
hit  out  1  one-cycle pulse, accepted key matched
miss  out  1  one-cycle pulse, accepted key mismatched
busy  out  1  high in every state except IDLE, WIN, LOSE
win  out  1  level, game won
lose  out  1  level, game lost

Behaviour:
- Reset (R=1, async): state IDLE; reg_E=0, led=0, led_valid=0, round_out=0, hit=0, miss=0, win=0, lose=0; idx=0; timers=0.
- States: IDLE, LOAD, SHOW, GAP, WAIT_KEY, WIN, LOSE. All outputs registered.
- IDLE/WIN/LOSE with start=1 -> LOAD. Clears win/lose and sets round_out=1, idx=0.
- LOAD: reg_E=1 for exactly this one cycle -> SHOW. seq_q is first sampled in the cycle after LOAD.
- SHOW: led=nibble[idx], led_valid=1 for SHOW_CYCLES cycles -> GAP.
- GAP: led_valid=0, led holds its last value, for GAP_CYCLES cycles.
  - If idx<round_out-1: idx++ -> SHOW.
  - Otherwise: idx=0 -> WAIT_KEY.
- WAIT_KEY, on key_valid:
  - key==nibble[idx] and idx<round_out-1: hit pulse next cycle, idx++.
  - key==nibble[idx] and idx==round_out-1: hit pulse. If round_out==N_NIBBLES -> WIN. Otherwise round_out++, idx=0 -> SHOW.
  - key!=nibble[idx]: miss pulse -> LOSE.
- hit/miss assert the cycle after the accepted key_valid, one cycle wide, never together.
- key_valid outside WAIT_KEY is ignored: no hit/miss, no state change.
- start outside IDLE/WIN/LOSE is ignored.
- WIN: win=1 held. LOSE: lose=1 held. round_out is frozen in both until start or R.
- R asserted mid-round returns everything to reset values immediately. reg_E is forced low.
- round_out never exceeds N_NIBBLES; idx never exceeds round_out-1.

Optional Feature:
KEY_TIMEOUT_EN
- Defined:
  - WAIT_KEY runs a counter cleared on entry and on every accepted key.
  - If TIMEOUT_CYCLES cycles elapse without key_valid, miss pulses -> LOSE.
  - A key_valid arriving in the same cycle the limit is reached takes priority and is compared normally.
- Undefined: no counter; WAIT_KEY waits indefinitely.

Test Plan:
1. Reset then start=1 with seq_q=64'h0123456789ABCDEF -> reg_E high exactly one cycle, round_out=1, led=0x0 with led_valid=1 for 4 cycles, then 2 blank cycles, busy=1.
2. Round 1 key 0x0 -> hit pulse, round_out=2. Replay shows 0x0 then 0x1 (4 on, 2 off each). Keys 0x0, 0x1 -> two hits, round_out=3.
3. In round 3, keys 0x0, 0x1, 0x5 -> hits on the first two, miss on the third, lose=1, busy=0, round_out=3 frozen; start=1 -> lose clears, round_out=1, reg_E pulses.
4. Play all 16 rounds correctly -> after key 0xF in round 16, win=1, round_out=16, no further SHOW. key_valid while in SHOW/GAP -> no hit/miss and no state change.
5. R asserted during WAIT_KEY of round 5 -> all outputs at reset values in the same cycle. After release, state is IDLE.
6. With KEY_TIMEOUT_EN: no key for 32 cycles in WAIT_KEY -> miss pulse, lose=1. A key at cycle 31 restarts the count. Without the macro, 1000 idle cycles leave the state in WAIT_KEY.
